// File: rtl/mux_2to1.sv
// Registered 2:1 data selector with capture enable and a valid flag.
// The data path is captured whether or not the cycle is qualified; out_valid carries qualification.
module mux_2to1 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    logic [WIDTH-1:0] out_d, out_q;
    logic             valid_d, valid_q;

    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        if (en) begin
            out_d   = sel ? b : a;
            valid_d = in_valid;
        end
    end

    // Reset wins over en, so a selection pending on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_2to1.sv
// Directed and randomized bench for mux_2to1 against a cycle-level reference model.
module tb_mux_2to1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [31:0] a;
    logic [31:0] b;
    logic        sel;
    logic        in_valid;
    logic [31:0] out;
    logic        out_valid;

    int checks = 0;
    int errors = 0;

    // Reference state: what out/out_valid should hold after the most recent edge.
    logic [31:0] exp_out;
    logic        exp_valid;

    mux_2to1 #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Advance one rising edge, updating the model from the inputs seen at that edge.
    task automatic tick();
        logic [31:0] nxt_out;
        logic        nxt_valid;
        nxt_out   = exp_out;
        nxt_valid = exp_valid;
        if (!rst_n) begin
            nxt_out   = 32'h0;
            nxt_valid = 1'b0;
        end else if (en) begin
            nxt_out   = (sel == 1'b1) ? b : a;
            nxt_valid = in_valid;
        end
        @(posedge clk);
        #1;
        exp_out   = nxt_out;
        exp_valid = nxt_valid;
    endtask

    initial begin
        exp_out   = 32'hx;
        exp_valid = 1'bx;
        rst_n     = 1'b0;
        en        = 1'b1;
        a         = 32'h1;
        b         = 32'h2;
        sel       = 1'b0;
        in_valid  = 1'b1;

        // Reset for two edges
        tick();
        tick();
        check("reset_out", out, 32'h0);
        check("reset_valid", {31'b0, out_valid}, 32'h0);

        // Select a, then b
        rst_n = 1'b1;
        tick();
        check("sel_a_out", out, 32'h1);
        check("sel_a_valid", {31'b0, out_valid}, 32'h1);

        sel = 1'b1;
        a   = 32'h1234_5678;
        #3;
        check("no_comb_path", out, 32'h1);
        a = 32'h1;
        tick();
        check("sel_b_out", out, 32'h2);
        check("sel_b_valid", {31'b0, out_valid}, 32'h1);

        // Hold with en low
        en = 1'b0;
        a  = 32'hDEAD_BEEF;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sel = ~sel;
            tick();
            check("hold_out", out, 32'h2);
            check("hold_valid", {31'b0, out_valid}, 32'h1);
        end

        // Reset priority over en
        en       = 1'b1;
        in_valid = 1'b1;
        sel      = 1'b1;
        b        = 32'hFFFF_FFFF;
        rst_n    = 1'b0;
        tick();
        check("rstprio_out", out, 32'h0);
        check("rstprio_valid", {31'b0, out_valid}, 32'h0);
        rst_n = 1'b1;
        tick();
        check("post_rst_out", out, 32'hFFFF_FFFF);
        check("post_rst_valid", {31'b0, out_valid}, 32'h1);

        // Unqualified data still captured
        in_valid = 1'b0;
        sel      = 1'b0;
        a        = 32'h5;
        tick();
        check("qual_out", out, 32'h5);
        check("qual_valid", {31'b0, out_valid}, 32'h0);

        // a == b regardless of sel
        a = 32'hA5A5_0F0F;
        b = 32'hA5A5_0F0F;
        in_valid = 1'b1;
        sel = 1'b0;
        tick();
        check("eq_sel0", out, 32'hA5A5_0F0F);
        sel = 1'b1;
        tick();
        check("eq_sel1", out, 32'hA5A5_0F0F);

        // Randomized traffic against the model
        for (int i = 0; i < 1000; i++) begin
            rst_n    = ($urandom_range(0, 49) != 0);
            en       = ($urandom_range(0, 3) != 0);
            a        = $urandom;
            b        = $urandom;
            sel      = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            tick();
            check("rand_out", out, exp_out);
            check("rand_valid", {31'b0, out_valid}, {31'b0, exp_valid});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
